// File: rtl/my_fifo_param.sv
// rtl/my_fifo_param.sv - parametrised single-clock FIFO with count, almost flags and sticky errors
// Optional first-word-fall-through read port when FIFO_FWFT_EN is defined.
module my_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_TH  = 14,
  parameter int AE_TH  = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        wen,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        ren,
  output logic [DATA_W-1:0]           out_data,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_TH);
  localparam logic            AF_RST  = (AF_TH == 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_q;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses only this port's own flag, never the other port's request.
  assign wr_acc  = wen && !full;
  assign rd_acc  = ren && !empty;
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage is not reset; the nrst gate keeps a write from landing during reset.
  always_ff @(posedge clk) begin
    if (wr_acc && nrst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
    end
  end

  // Last popped word; the standard read data, and the FWFT value while empty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q <= '0;
    end else if (rd_acc) begin
      out_q <= rd_word;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && full)  overflow  <= 1'b1;
      if (ren && empty) underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign out_data = empty ? out_q : rd_word;
`else
  assign out_data = out_q;
`endif

endmodule

// File: tb/tb_my_fifo_param.sv
// tb/tb_my_fifo_param.sv - randomized self-checking bench for my_fifo_param against a queue model
// Honours FIFO_FWFT_EN to select the expected read-port behaviour.
module tb_my_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_TH  = 14;
  localparam int AE_TH  = 2;

  logic              clk = 1'b0;
  logic              nrst;
  logic              wen;
  logic [DATA_W-1:0] in_data;
  logic              ren;
  logic [DATA_W-1:0] out_data;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [4:0]        count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] last_pop;
  logic              m_ovf;
  logic              m_udf;

  my_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)
  ) dut (
    .clk(clk), .nrst(nrst), .wen(wen), .in_data(in_data), .ren(ren),
    .out_data(out_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_out();
`ifdef FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : last_pop;
`else
    return last_pop;
`endif
  endfunction

  task automatic compare_all();
    check("count",        32'(count),        32'(q.size()));
    check("empty",        32'(empty),        32'(q.size() == 0));
    check("full",         32'(full),         32'(q.size() == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE_TH));
    check("almost_full",  32'(almost_full),  32'(q.size() >= AF_TH));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
    check("out_data",     32'(out_data),     32'(exp_out()));
  endtask

  task automatic model_reset();
    q.delete();
    last_pop = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // One clock with the given request; model updated from its pre-edge state.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    bit wa, ra;
    wen = w; in_data = d; ren = r; clr_err = c;
    @(posedge clk);
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_udf = 1'b1;
    end
    if (ra) last_pop = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    compare_all();
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; wen = 1'b0; ren = 1'b0; clr_err = 1'b0; in_data = '0;
    model_reset();
    #12;
    compare_all();
    nrst = 1'b1;
    @(negedge clk);

    // Fill 1..16, then one write too many.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0);
      check("af_from_14", 32'(almost_full), 32'(i >= 14));
    end
    check("full_at_16", 32'(full), 32'd1);
    step(1'b1, 8'd17, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("count_stays_16", 32'(count), 32'd16);

    // Drain in order, then one read too many.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
      check("rd_order", 32'(out_data), 32'(i));
`endif
    end
    check("empty_after_drain", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", 32'(underflow), 32'd1);
    check("out_holds_16", 32'(out_data), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Interleaved traffic across pointer wrap, occupancy kept <= 5.
    for (int i = 0; i < 40; i++) begin
      logic w, r;
      w = (q.size() < 5) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1) && (q.size() > 0);
      step(w, DATA_W'($urandom), r, 1'b0);
    end
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous access at count 8, full and empty.
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h3c, 1'b1, 1'b0);
    check("both_at_8", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("both_at_full_cnt", 32'(count), 32'd15);
    check("both_at_full_ovf", 32'(overflow), 32'd1);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5a, 1'b1, 1'b0);
    check("both_at_empty_cnt", 32'(count), 32'd1);
    check("both_at_empty_udf", 32'(underflow), 32'd1);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_udf", 32'(underflow), 32'd0);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef FIFO_FWFT_EN
    step(1'b1, 8'ha5, 1'b0, 1'b0);
    check("fwft_head", 32'(out_data), 32'ha5);
    step(1'b1, 8'h3b, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_next", 32'(out_data), 32'h3b);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_empty", 32'(empty), 32'd1);
`endif

    // Free-running random traffic including error clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, DATA_W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 30; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);

    // Asynchronous reset mid-stream with a write pending.
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    wen = 1'b1; in_data = 8'hee;
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    compare_all();
    wen = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_data", 32'(out_data), 32'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
